des_dec_key_sched: RTL and testbench

Sequential DES subkey generator for the decryption direction. Takes a 64-bit key, applies PC-1, and streams the 16 round subkeys in reverse order, K16 first and K1 last. Uses right rotations of the 28-bit C/D halves and PC-2 selection. Sits between the key register and the decryption round datapath, and feeds one 48-bit subkey per accepted handshake.

---
 rtl/des_dec_key_sched.sv | 133 +++++++++++++
 tb/tb_des_dec_key_sched.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/des_dec_key_sched.sv
// DES decryption-direction subkey generator: streams K16..K1 over a valid/ready handshake.
// Optional key parity checking is enabled by defining DES_KEY_PARITY_CHK_EN.
module des_dec_key_sched (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [64:1] key_in,
  input  logic        start,
  output logic        busy,
  output logic [48:1] subkey_out,
  output logic        subkey_valid,
  input  logic        subkey_ready,
  output logic [4:0]  subkey_idx,
  output logic        subkey_last,
  output logic        key_err
);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;

  // Tables use DES bit numbers (1 = MSB); vector index of DES bit j in an N-bit bus is N+1-j.
  localparam int unsigned PC1_TBL [56] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
  };

  localparam int unsigned PC2_TBL [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
  };

  function automatic logic [56:1] pc1(input logic [64:1] k);
    logic [56:1] r;
    r = '0;
    for (int unsigned i = 0; i < 56; i++)
      r[6'(56 - i)] = k[7'(65 - PC1_TBL[i])];
    return r;
  endfunction

  function automatic logic [48:1] pc2(input logic [56:1] cd_v);
    logic [48:1] r;
    r = '0;
    for (int unsigned i = 0; i < 48; i++)
      r[6'(48 - i)] = cd_v[6'(57 - PC2_TBL[i])];
    return r;
  endfunction

  logic [0:0]  state;
  logic [56:1] cd;
  logic [4:0]  idx;
  logic [56:1] cd_rot;
  logic [4:0]  idx_next;
  logic        rot_one;

  // Right rotation in DES numbering moves bits toward the vector LSB, bit 28 wrapping to bit 1.
  always_comb begin
    idx_next = idx - 5'd1;
    rot_one  = (idx_next == 5'd15) || (idx_next == 5'd8) || (idx_next == 5'd1);
    if (rot_one)
      cd_rot = {cd[29], cd[56:30], cd[1], cd[28:2]};
    else
      cd_rot = {cd[30:29], cd[56:31], cd[2:1], cd[28:3]};
  end

`ifdef DES_KEY_PARITY_CHK_EN
  function automatic logic parity_ok(input logic [64:1] k);
    logic ok;
    ok = 1'b1;
    for (int unsigned b = 0; b < 8; b++)
      if (!(^k[7'(8 * b + 8) -: 8])) ok = 1'b0;
    return ok;
  endfunction

  logic err_q;
  assign key_err = err_q;
`else
  assign key_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      cd    <= '0;
      idx   <= '0;
`ifdef DES_KEY_PARITY_CHK_EN
      err_q <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
`ifdef DES_KEY_PARITY_CHK_EN
            if (parity_ok(key_in)) begin
              cd    <= pc1(key_in);
              idx   <= 5'd16;
              state <= S_RUN;
              err_q <= 1'b0;
            end else begin
              err_q <= 1'b1;
            end
`else
            cd    <= pc1(key_in);
            idx   <= 5'd16;
            state <= S_RUN;
`endif
          end
        end
        S_RUN: begin
          if (subkey_ready) begin
            if (idx == 5'd1) begin
              state <= S_IDLE;
              idx   <= '0;
            end else begin
              cd  <= cd_rot;
              idx <= idx_next;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign busy         = (state == S_RUN);
  assign subkey_valid = (state == S_RUN);
  assign subkey_last  = (state == S_RUN) && (idx == 5'd1);
  assign subkey_idx   = idx;
  assign subkey_out   = pc2(cd);

endmodule

// File: tb/tb_des_dec_key_sched.sv
// Self-checking bench for des_dec_key_sched using the classic 133457799BBCDFF1 key schedule.
module tb_des_dec_key_sched;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [64:1] key_in = '0;
  logic        start = 1'b0;
  logic        busy;
  logic [48:1] subkey_out;
  logic        subkey_valid;
  logic        subkey_ready = 1'b1;
  logic [4:0]  subkey_idx;
  logic        subkey_last;
  logic        key_err;

  always #5 clk = ~clk;

  des_dec_key_sched dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .key_in       (key_in),
    .start        (start),
    .busy         (busy),
    .subkey_out   (subkey_out),
    .subkey_valid (subkey_valid),
    .subkey_ready (subkey_ready),
    .subkey_idx   (subkey_idx),
    .subkey_last  (subkey_last),
    .key_err      (key_err)
  );

  typedef struct {
    logic [4:0]  idx;
    logic [47:0] sk;
    logic        last;
  } vec_t;

  localparam logic [63:0] KEY_A = 64'h133457799BBCDFF1;

  vec_t        tbl [16];
  logic [47:0] enc_k [1:16];
  int          n_pass = 0;
  int          n_total = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [63:0] k);
    key_in = k;
    start  = 1'b1;
    step();
    start  = 1'b0;
  endtask

  task automatic chk_vec(input string tag, input int i);
    chk($sformatf("%s sk[%0d]", tag, i), 64'(subkey_out), 64'(tbl[i].sk));
    chk($sformatf("%s idx[%0d]", tag, i), 64'(subkey_idx), 64'(tbl[i].idx));
    chk($sformatf("%s last[%0d]", tag, i), 64'(subkey_last), 64'(tbl[i].last));
    chk($sformatf("%s valid[%0d]", tag, i), 64'(subkey_valid), 64'd1);
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, " busy"}, 64'(busy), 64'd0);
    chk({tag, " valid"}, 64'(subkey_valid), 64'd0);
    chk({tag, " idx"}, 64'(subkey_idx), 64'd0);
  endtask

  initial begin
    enc_k[1]  = 48'h1B02EFFC7072; enc_k[2]  = 48'h79AED9DBC9E5;
    enc_k[3]  = 48'h55FC8A42CF99; enc_k[4]  = 48'h72ADD6DB351D;
    enc_k[5]  = 48'h7CEC07EB53A8; enc_k[6]  = 48'h63A53E507B2F;
    enc_k[7]  = 48'hEC84B7F618BC; enc_k[8]  = 48'hF78A3AC13BFB;
    enc_k[9]  = 48'hE0DBEBEDE781; enc_k[10] = 48'hB1F347BA464F;
    enc_k[11] = 48'h215FD3DED386; enc_k[12] = 48'h7571F59467E9;
    enc_k[13] = 48'h97C5D1FABA41; enc_k[14] = 48'h5F43B7F2E73A;
    enc_k[15] = 48'hBF918D3D3F0A; enc_k[16] = 48'hCB3D8B0E17F5;
    for (int i = 0; i < 16; i++) begin
      tbl[i].idx  = 5'(16 - i);
      tbl[i].sk   = enc_k[16 - i];
      tbl[i].last = (i == 15);
    end

    // Reset state
    #12;
    chk("rst subkey_out", 64'(subkey_out), 64'd0);
    chk_idle("rst");
    chk("rst last", 64'(subkey_last), 64'd0);
    chk("rst key_err", 64'(key_err), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // Basic schedule, ready held high
    do_start(KEY_A);
    for (int i = 0; i < 16; i++) begin
      chk_vec("basic", i);
      step();
    end
    chk_idle("basic end");

    // Back-to-back restart on the edge after busy drops, with backpressure at idx 12
    do_start(KEY_A);
    for (int i = 0; i < 16; i++) begin
      chk_vec("bp", i);
      if (i == 4) begin
        subkey_ready = 1'b0;
        for (int h = 0; h < 3; h++) begin
          step();
          chk($sformatf("bp hold sk %0d", h), 64'(subkey_out), 64'(enc_k[12]));
          chk($sformatf("bp hold idx %0d", h), 64'(subkey_idx), 64'd12);
        end
        subkey_ready = 1'b1;
      end
      step();
    end
    chk_idle("bp end");

    // Start during busy at idx 9 is ignored
    do_start(KEY_A);
    for (int i = 0; i < 16; i++) begin
      chk_vec("sdb", i);
      if (i == 7) begin
        key_in = 64'hFFFFFFFFFFFFFFFF;
        start  = 1'b1;
      end
      step();
      start = 1'b0;
    end
    chk_idle("sdb end");
    step();

    // Async reset at idx 5
    do_start(KEY_A);
    for (int i = 0; i < 11; i++) step();
    chk("ar pre idx", 64'(subkey_idx), 64'd5);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar subkey_out", 64'(subkey_out), 64'd0);
    chk_idle("ar");
    @(negedge clk);
    rst_n = 1'b1;
    step();
    do_start(KEY_A);
    chk_vec("ar restart", 0);
    for (int i = 0; i < 16; i++) step();
    chk_idle("ar restart end");

`ifdef DES_KEY_PARITY_CHK_EN
    do_start(64'h133457799BBCDFF0);
    chk("par bad key_err", 64'(key_err), 64'd1);
    chk("par bad busy", 64'(busy), 64'd0);
    step();
    chk("par bad busy later", 64'(busy), 64'd0);
    do_start(KEY_A);
    chk("par good key_err", 64'(key_err), 64'd0);
    for (int i = 0; i < 16; i++) begin
      chk_vec("par", i);
      step();
    end
    chk_idle("par end");
`else
    // Parity ignored: a bad-parity key is still accepted
    do_start(64'h133457799BBCDFF0);
    chk("nopar key_err", 64'(key_err), 64'd0);
    chk("nopar busy", 64'(busy), 64'd1);
    chk("nopar K16", 64'(subkey_out), 64'(enc_k[16]));
    for (int i = 0; i < 16; i++) step();
    chk_idle("nopar end");

    do_start(64'h0);
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("zero sk[%0d]", i), 64'(subkey_out), 64'd0);
      chk($sformatf("zero idx[%0d]", i), 64'(subkey_idx), 64'(16 - i));
      step();
    end
    chk_idle("zero end");

    do_start(64'hFFFFFFFFFFFFFFFF);
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("ones sk[%0d]", i), 64'(subkey_out), 64'hFFFFFFFFFFFF);
      chk($sformatf("ones idx[%0d]", i), 64'(subkey_idx), 64'(16 - i));
      step();
    end
    chk_idle("ones end");
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
